// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, the GF(2^8) reduction polynomial, the column engine FSM
// encoding and the xtime primitive used by the MixColumns datapaths.
package aes_pkg;

   localparam int BYTE   = 8;
   localparam int DWORD  = 32;
   localparam int LENGTH = 128;

   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_state_t;

   // Multiply by x in GF(2^8), reducing by the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      logic [7:0] shifted;
      shifted = {b[6:0], 1'b0};
      if (b[7]) begin
         return shifted ^ GF_POLY;
      end else begin
         return shifted;
      end
   endfunction

endpackage

// File: rtl/inv_set_columns_if.sv
// inv_set_columns_if: input and output valid/ready channels of the column engine.
// The fwd select only exists when INV_SET_COLUMNS_FWD_EN is defined.
interface inv_set_columns_if;
   import aes_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [LENGTH-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [LENGTH-1:0] out_data;
`ifdef INV_SET_COLUMNS_FWD_EN
   logic              fwd;
`endif

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
`ifdef INV_SET_COLUMNS_FWD_EN
      , output fwd
`endif
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
`ifdef INV_SET_COLUMNS_FWD_EN
      , input fwd
`endif
   );

endinterface

// File: rtl/inv_col_mix.sv
// inv_col_mix: combinational single-column InvMixColumns (and, with
// INV_SET_COLUMNS_FWD_EN, forward MixColumns selected by fwd).
module inv_col_mix
   import aes_pkg::*;
(
   input  logic [DWORD-1:0] col_in,
`ifdef INV_SET_COLUMNS_FWD_EN
   input  logic             fwd,
`endif
   output logic [DWORD-1:0] col_out
);

   logic [BYTE-1:0] a_s  [4];
   logic [BYTE-1:0] x2_s [4];
   logic [BYTE-1:0] x4_s [4];
   logic [BYTE-1:0] x8_s [4];
   logic [BYTE-1:0] m9_s [4];
   logic [BYTE-1:0] mb_s [4];
   logic [BYTE-1:0] md_s [4];
   logic [BYTE-1:0] me_s [4];
   logic [DWORD-1:0] inv_word_s;

   // Per-byte xtime chain and the four inverse-matrix multiples built from it
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a_s[i]  = col_in[DWORD-1-BYTE*i -: BYTE];
         x2_s[i] = xtime(a_s[i]);
         x4_s[i] = xtime(x2_s[i]);
         x8_s[i] = xtime(x4_s[i]);
         m9_s[i] = x8_s[i] ^ a_s[i];
         mb_s[i] = x8_s[i] ^ x2_s[i] ^ a_s[i];
         md_s[i] = x8_s[i] ^ x4_s[i] ^ a_s[i];
         me_s[i] = x8_s[i] ^ x4_s[i] ^ x2_s[i];
      end
   end

   assign inv_word_s = {
      me_s[0] ^ mb_s[1] ^ md_s[2] ^ m9_s[3],
      m9_s[0] ^ me_s[1] ^ mb_s[2] ^ md_s[3],
      md_s[0] ^ m9_s[1] ^ me_s[2] ^ mb_s[3],
      mb_s[0] ^ md_s[1] ^ m9_s[2] ^ me_s[3]
   };

`ifdef INV_SET_COLUMNS_FWD_EN
   logic [BYTE-1:0]  x3_s [4];
   logic [DWORD-1:0] fwd_word_s;

   // Multiples of 3 for the forward matrix {02,03,01,01}
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         x3_s[i] = x2_s[i] ^ a_s[i];
      end
   end

   assign fwd_word_s = {
      x2_s[0] ^ x3_s[1] ^ a_s[2]  ^ a_s[3],
      a_s[0]  ^ x2_s[1] ^ x3_s[2] ^ a_s[3],
      a_s[0]  ^ a_s[1]  ^ x2_s[2] ^ x3_s[3],
      x3_s[0] ^ a_s[1]  ^ a_s[2]  ^ x2_s[3]
   };

   assign col_out = fwd ? fwd_word_s : inv_word_s;
`else
   assign col_out = inv_word_s;
`endif

endmodule

// File: rtl/inv_set_columns.sv
// inv_set_columns: iterative AES InvMixColumns engine, one 32-bit column per cycle.
// Defining INV_SET_COLUMNS_FWD_EN adds a per-block fwd select for forward MixColumns.
module inv_set_columns
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   inv_set_columns_if.slave  bus
);

   fsm_state_t        state_r;
   fsm_state_t        state_nxt_s;
   logic [1:0]        col_r;
   logic [LENGTH-1:0] data_r;
   logic [LENGTH-1:0] data_nxt_s;
   logic              out_valid_r;
   logic              in_ready_s;
   logic              accept_s;
   logic              out_hs_s;
   logic              last_col_s;
   logic [DWORD-1:0]  col_word_s;
   logic [DWORD-1:0]  col_mixed_s;
`ifdef INV_SET_COLUMNS_FWD_EN
   logic              fwd_r;
`endif

   assign accept_s   = bus.in_valid & in_ready_s;
   assign out_hs_s   = out_valid_r & bus.out_ready;
   assign last_col_s = (col_r == 2'd3);

   // Next-state decode; in DONE a new block may enter on the same edge the result leaves
   always_comb begin
      state_nxt_s = state_r;
      in_ready_s  = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = 1'b1;
            if (bus.in_valid) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (last_col_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            in_ready_s = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            in_ready_s  = 1'b0;
         end
      endcase
   end

   // Route the column addressed by col_r into the shared mixer
   always_comb begin
      col_word_s = data_r[0*DWORD +: DWORD];
      case (col_r)
         2'd0:    col_word_s = data_r[0*DWORD +: DWORD];
         2'd1:    col_word_s = data_r[1*DWORD +: DWORD];
         2'd2:    col_word_s = data_r[2*DWORD +: DWORD];
         2'd3:    col_word_s = data_r[3*DWORD +: DWORD];
         default: col_word_s = data_r[0*DWORD +: DWORD];
      endcase
   end

   inv_col_mix u_mix (
      .col_in  (col_word_s),
`ifdef INV_SET_COLUMNS_FWD_EN
      .fwd     (fwd_r),
`endif
      .col_out (col_mixed_s)
   );

   // Merge the mixed column back into its slot, other columns untouched
   always_comb begin
      data_nxt_s = data_r;
      case (col_r)
         2'd0:    data_nxt_s[0*DWORD +: DWORD] = col_mixed_s;
         2'd1:    data_nxt_s[1*DWORD +: DWORD] = col_mixed_s;
         2'd2:    data_nxt_s[2*DWORD +: DWORD] = col_mixed_s;
         2'd3:    data_nxt_s[3*DWORD +: DWORD] = col_mixed_s;
         default: data_nxt_s = data_r;
      endcase
   end

   // State register, column counter, block buffer and result-valid flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         col_r       <= 2'd0;
         data_r      <= '0;
         out_valid_r <= 1'b0;
`ifdef INV_SET_COLUMNS_FWD_EN
         fwd_r       <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            data_r <= bus.in_data;
            col_r  <= 2'd0;
`ifdef INV_SET_COLUMNS_FWD_EN
            fwd_r  <= bus.fwd;
`endif
         end else if (state_r == RUN) begin
            data_r <= data_nxt_s;
            col_r  <= col_r + 2'd1;
         end else begin
            data_r <= data_r;
            col_r  <= col_r;
         end
         if ((state_r == RUN) && last_col_s) begin
            out_valid_r <= 1'b1;
         end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = data_r;

endmodule

// File: tb/tb_inv_set_columns.sv
// tb_inv_set_columns: directed bench for inv_set_columns with a cycle-level
// behavioural model (generic GF multiply, circulant matrices) checked every cycle.
module tb_inv_set_columns;
   import aes_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   bit   cmp_en = 1'b0;

   inv_set_columns_if bus ();

   inv_set_columns dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Generic shift-and-add multiplication in GF(2^8) mod x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] x;
      logic [7:0] p;
      p = 8'h00;
      x = {1'b0, a};
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x[7:0];
         x = x << 1;
         if (x[8]) x = x ^ 9'h11B;
      end
      return p;
   endfunction

   // Row i of a circulant matrix uses coefficient (j - i) mod 4 for byte j
   function automatic logic [31:0] model_col(input logic [31:0] c, input logic fwd);
      logic [7:0] coef [4];
      logic [7:0] a    [4];
      logic [7:0] r;
      logic [31:0] res;
      if (fwd) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      else     coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
      for (int j = 0; j < 4; j++) a[j] = c[31-8*j -: 8];
      res = 32'h0;
      for (int i = 0; i < 4; i++) begin
         r = 8'h00;
         for (int j = 0; j < 4; j++) r = r ^ gf_mul(coef[(j - i + 4) % 4], a[j]);
         res[31-8*i -: 8] = r;
      end
      return res;
   endfunction

   function automatic logic [127:0] model_state(input logic [127:0] s, input logic fwd);
      logic [127:0] o;
      for (int w = 0; w < 4; w++) o[32*w +: 32] = model_col(s[32*w +: 32], fwd);
      return o;
   endfunction

   // Cycle-level model: a block finishes 4 edges after acceptance, then waits for out_ready
   int           m_cnt   = 0;
   bit           m_valid = 1'b0;
   logic [127:0] m_data  = '0;
   logic [127:0] m_pend  = '0;

   function automatic bit model_ready();
      return ((m_cnt == 0) && !m_valid) || (m_valid && bus.out_ready);
   endfunction

   always @(posedge clk) begin
      bit   acc;
      bit   hs;
      logic fwd_now;
`ifdef INV_SET_COLUMNS_FWD_EN
      fwd_now = bus.fwd;
`else
      fwd_now = 1'b0;
`endif
      if (!rst_n) begin
         m_cnt   = 0;
         m_valid = 1'b0;
         m_data  = '0;
      end else begin
         acc = bus.in_valid && model_ready();
         hs  = m_valid && bus.out_ready;
         if (hs) m_valid = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_valid = 1'b1;
               m_data  = m_pend;
            end
         end
         if (acc) begin
            m_pend = model_state(bus.in_data, fwd_now);
            m_cnt  = 4;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_in_ready", {127'd0, bus.in_ready}, {127'd0, model_ready()});
         check("cyc_out_valid", {127'd0, bus.out_valid}, {127'd0, m_valid});
         if (m_valid) check("cyc_out_data", bus.out_data, m_data);
      end
   end

   task automatic send(input logic [127:0] d);
      bit rdy;
      rdy = 1'b0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) break;
      end
      #1;
      bus.in_valid = 1'b0;
      if (!rdy) check("send_timeout", 128'd0, 128'd1);
   endtask

   task automatic recv(output logic [127:0] d, output int lat);
      lat = -1;
      d   = '0;
      bus.out_ready = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            d   = bus.out_data;
            lat = n - 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      if (lat < 0) check("recv_timeout", 128'd0, 128'd1);
   endtask

   localparam logic [127:0] FULL_IN  = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};
   localparam logic [127:0] FULL_OUT = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
   localparam logic [127:0] MIX_IN   = {32'hd5d5d7d6, 32'h9fdc589d, 32'h8e4da1bc, 32'h01010101};
   localparam logic [127:0] MIX_OUT  = {32'hd4d4d4d5, 32'hf20a225c, 32'hdb135345, 32'h01010101};
   localparam logic [127:0] ONE_IN   = {96'h0, 32'h8e4da1bc};
   localparam logic [127:0] ONE_OUT  = {96'h0, 32'hdb135345};

   initial begin
      logic [127:0] res;
      logic [127:0] held;
      int           lat;
      logic [127:0] b2b_in  [3];
      logic [127:0] b2b_exp [3];
      logic [127:0] got     [3];
      int           acc_cyc [3];
      int           hs_cyc  [3];
      int           n_acc;
      int           n_out;
      bit           rdy;
      bit           ov;
      logic [127:0] od;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
`ifdef INV_SET_COLUMNS_FWD_EN
      bus.fwd       = 1'b0;
`endif
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
      check("rst_out_data", bus.out_data, 128'd0);
      check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

      // Pin the model against hand-computed columns
      check("model_inv_a", {96'd0, model_col(32'h8e4da1bc, 1'b0)}, {96'd0, 32'hdb135345});
      check("model_inv_b", {96'd0, model_col(32'h9fdc589d, 1'b0)}, {96'd0, 32'hf20a225c});
      check("model_inv_c", {96'd0, model_col(32'hd5d5d7d6, 1'b0)}, {96'd0, 32'hd4d4d4d5});
      check("model_fwd_a", {96'd0, model_col(32'hdb135345, 1'b1)}, {96'd0, 32'h8e4da1bc});

      // Single column and latency
      @(posedge clk);
      #1;
      send(ONE_IN);
      recv(res, lat);
      check("single_data", res, ONE_OUT);
      check("single_latency", 128'(lat), 128'd4);

      // Full state
      send(FULL_IN);
      recv(res, lat);
      check("full_data", res, FULL_OUT);
      check("full_latency", 128'(lat), 128'd4);

      // Backpressure: ten cycles of out_ready low while DONE
      send(MIX_IN);
      held = '0;
      ov   = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            held = bus.out_data;
            ov   = 1'b1;
            break;
         end
      end
      check("bp_reached_done", {127'd0, ov}, 128'd1);
      check("bp_data", held, MIX_OUT);
      for (int n = 0; n < 10; n++) begin
         if (n > 0) @(negedge clk);
         check("bp_hold_valid", {127'd0, bus.out_valid}, 128'd1);
         check("bp_hold_data", bus.out_data, held);
         check("bp_hold_in_ready", {127'd0, bus.in_ready}, 128'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("bp_release_valid", {127'd0, bus.out_valid}, 128'd0);
      check("bp_release_idle", {127'd0, bus.in_ready}, 128'd1);

      // Back-to-back with in_valid and out_ready held high
      @(posedge clk);
      #1;
      b2b_in  = '{FULL_IN, ONE_IN, MIX_IN};
      b2b_exp = '{FULL_OUT, ONE_OUT, MIX_OUT};
      n_acc = 0;
      n_out = 0;
      bus.in_data   = b2b_in[0];
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         ov  = bus.out_valid;
         od  = bus.out_data;
         @(posedge clk);
         if (ov && n_out < 3) begin
            got[n_out]    = od;
            hs_cyc[n_out] = cyc;
            n_out++;
         end
         if (rdy && bus.in_valid && n_acc < 3) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         #1;
         if (n_acc < 3) bus.in_data = b2b_in[n_acc];
         else bus.in_valid = 1'b0;
         if (n_out == 3) break;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("b2b_outputs", 128'(n_out), 128'd3);
      if (n_out == 3) begin
         check("b2b_period_1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd5);
         check("b2b_period_2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd5);
         check("b2b_same_edge_1", 128'(hs_cyc[0]), 128'(acc_cyc[1]));
         check("b2b_same_edge_2", 128'(hs_cyc[1]), 128'(acc_cyc[2]));
         for (int i = 0; i < 3; i++) check("b2b_data", got[i], b2b_exp[i]);
      end

      // Reset after two columns have been transformed
      @(posedge clk);
      #1;
      send(FULL_IN);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", {127'd0, bus.out_valid}, 128'd0);
      check("midrst_out_data", bus.out_data, 128'd0);
      check("midrst_in_ready", {127'd0, bus.in_ready}, 128'd1);
      @(posedge clk);
      #1;
      send(MIX_IN);
      recv(res, lat);
      check("midrst_next_data", res, MIX_OUT);

`ifdef INV_SET_COLUMNS_FWD_EN
      // Forward matrix, then round trip through the inverse
      bus.fwd = 1'b1;
      send(FULL_OUT);
      bus.fwd = 1'b0;
      recv(res, lat);
      check("fwd_data", res, FULL_IN);
      send(res);
      recv(res, lat);
      check("fwd_round_trip", res, FULL_OUT);
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
